tutor_vhdl: RTL and testbench
=============================

Name: tutor_vhdl

Overview:
- Small 4-bit datapath built around a loadable up/down counter with clock enable.
- A separate data register captures DATA when LE is high.
- A 2:1 mux picks either the counter value or the captured data.
- The mux result drives Q through a tri-state output buffer.
- Serves as a tutorial/demo top level: board switches in, bus/LEDs out.

Parameters:
WIDTH, 4, bit width of DATA, counter, data register and Q.

Ports:
CLK   in   1      rising-edge system clock
CLR   in   1      asynchronous reset, active-low; clears counter and data register
CE    in   1      counter count enable, active-high
LOAD  in   1      synchronous counter load of DATA, active-high
DIR   in   1      count direction: 1 = up, 0 = down
SEL   in   1      output select: 0 = counter, 1 = data register
DATA  in   WIDTH  parallel data for counter load and data register
OE    in   1      output enable, active-high; 0 puts Q in high-Z
LE    in   1      data register enable, active-high
Q     out  WIDTH  tri-state output bus

Behaviour:
- Reset: CLR=0 asynchronously forces counter=0 and datareg=0, with no wait for CLK.
  - Both stay 0 while CLR=0.
  - Release is synchronous-safe: the first update happens on the first rising CLK with CLR=1.
- Counter, on rising CLK with CLR=1, priority high to low:
  - LOAD=1: counter <= DATA. Load ignores CE.
  - else CE=1 and DIR=1: counter <= counter+1, modulo 2^WIDTH (F->0 wraps).
  - else CE=1 and DIR=0: counter <= counter-1, modulo 2^WIDTH (0->F wraps).
  - else CE=0: counter holds.
- Data register, on rising CLK with CLR=1:
  - LE=1: datareg <= DATA.
  - LE=0: datareg holds.
  - Edge-triggered register, not a transparent latch.
- Mux: combinational. mux = SEL ? datareg : counter.
- Output: combinational. Q = OE ? mux : all-Z.
  - OE and SEL changes show on Q in the same cycle, with no register stage.
- Latency:
  - LOAD, count and LE effects appear on Q one CLK edge after sampling, when selected and OE=1.
  - SEL/OE effects are immediate.
- Simultaneous events:
  - CLR=0 overrides LOAD, CE and LE.
  - LOAD overrides CE/DIR.
  - LE and counter operations are independent and may occur in the same cycle.
- Counter and data register keep running while SEL hides them or OE=0.
- Reset mid-count: value goes to 0 immediately; counting resumes from 0 after release.
- No X propagation from DATA into the counter unless LOAD=1 or LE=1.

Decomposition:
- Shared package: WIDTH default constant (4) and the SEL encoding constants SEL_COUNTER=0, SEL_DATAREG=1.
- One natural sub-module: tutor_updown_counter (CLK, CLR, CE, LOAD, DIR, DATA -> count).
- Top level holds the data register, mux and tri-state buffer.

Test Plan:
1. Reset, load and count up:
   - Stimulus: CLR=0 with SEL=0, OE=1 -> Q=0000 immediately, no clock needed. Release CLR=1, then LOAD=1, DATA=0110 for one edge.
   - Response: Q=0110. Then CE=1, DIR=1 -> Q=0111, 1000, 1001 on successive edges.
2. Hold, wrap up, count down and wrap down:
   - Stimulus: CE=0 for 3 edges -> Q holds. CE=1, DIR=1 from 1111.
   - Response: Q=0000 (wrap up). DIR=0 from 0010 -> Q=0001, 0000, 1111 (wrap down).
3. LOAD priority:
   - Stimulus: LOAD=1 together with CE=1, DIR=1, DATA=0101.
   - Response: Q=0101, not incremented.
4. Tri-state:
   - Stimulus: OE=0 mid-count.
   - Response: Q=ZZZZ in the same cycle. OE=1 -> Q shows the counter, which advanced during the high-Z period.
5. Data register path, SEL=1:
   - Stimulus: LE=1, DATA=0001 on an edge.
   - Response: Q=0001. Then LE=0, DATA=0101 -> Q stays 0001. SEL=0 -> Q returns to the running counter value.
6. Asynchronous reset mid-operation:
   - Stimulus: CLR=0 pulse between clock edges while the counter=1010 and datareg=0001.
   - Response: Q=0000 immediately for both SEL settings, counting from 0000 after release.

Source files
------------

// File: rtl/tutor_vhdl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tutor_vhdl_pkg
// Description : Shared constants and types for the tutor_vhdl datapath:
//               default datapath width, output-select encoding and the
//               counter operation decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tutor_vhdl_pkg;

    // Default width of DATA, the counter, the data register and Q
    localparam int WIDTH_DEF = 4;

    // Output select encoding: which source drives the mux
    typedef enum logic {
        SEL_COUNTER = 1'b0,
        SEL_DATAREG = 1'b1
    } sel_e;

    // Counter operation chosen for the next rising clock edge
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_UP   = 2'd2,
        CNT_DOWN = 2'd3
    } cnt_op_e;

    // Resolve the counter controls into one operation.
    // LOAD wins over everything; CE gates counting; DIR picks direction.
    function automatic cnt_op_e decode_cnt_op(
        input logic i_load,
        input logic i_ce,
        input logic i_dir
    );
        cnt_op_e v_op;
        if (i_load) begin
            v_op = CNT_LOAD;
        end else if (i_ce && i_dir) begin
            v_op = CNT_UP;
        end else if (i_ce) begin
            v_op = CNT_DOWN;
        end else begin
            v_op = CNT_HOLD;
        end
        return v_op;
    endfunction

endpackage : tutor_vhdl_pkg
`default_nettype wire

// File: rtl/tutor_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tutor_updown_counter
// Description : Loadable up/down counter with count enable and asynchronous
//               active-low clear. Load has priority over counting; counting
//               wraps modulo 2^WIDTH in both directions.
// Revision    : 1.0 - initial release
// ============================================================================
module tutor_updown_counter
    import tutor_vhdl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic             LOAD,
    input  logic             DIR,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    cnt_op_e          w_op;

    assign w_op = decode_cnt_op(LOAD, CE, DIR);

    // Next-count selection; DATA only reaches the counter on a load, so an
    // unknown DATA cannot leak in while counting or holding
    always_comb begin
        w_count_next = r_count;
        case (w_op)
            CNT_LOAD: w_count_next = DATA;
            CNT_UP:   w_count_next = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
            CNT_DOWN: w_count_next = r_count - {{(WIDTH-1){1'b0}}, 1'b1};
            default:  w_count_next = r_count;
        endcase
    end

    // Count register, cleared immediately while CLR is low
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count = r_count;

endmodule : tutor_updown_counter
`default_nettype wire

// File: rtl/tutor_vhdl.sv
`default_nettype none
// ============================================================================
// Module      : tutor_vhdl
// Description : Tutorial datapath top level. An up/down counter and a data
//               register both take DATA; SEL picks one of them and OE gates
//               the choice onto the tri-state bus Q.
// Revision    : 1.0 - initial release
// ============================================================================
module tutor_vhdl
    import tutor_vhdl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic             LOAD,
    input  logic             DIR,
    input  logic             SEL,
    input  logic [WIDTH-1:0] DATA,
    input  logic             OE,
    input  logic             LE,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] r_datareg;
    logic [WIDTH-1:0] w_mux;
    sel_e             w_sel;

    // Counter keeps running regardless of SEL/OE
    tutor_updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .CLK   (CLK),
        .CLR   (CLR),
        .CE    (CE),
        .LOAD  (LOAD),
        .DIR   (DIR),
        .DATA  (DATA),
        .count (w_count)
    );

    // Edge-triggered data capture, independent of the counter controls
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_datareg <= '0;
        end else if (LE) begin
            r_datareg <= DATA;
        end
    end

    assign w_sel = sel_e'(SEL);

    // Source select; purely combinational so SEL acts within the cycle
    always_comb begin
        w_mux = w_count;
        if (w_sel == SEL_DATAREG) begin
            w_mux = r_datareg;
        end
    end

    // Tri-state output driver, also combinational
    assign Q = OE ? w_mux : {WIDTH{1'bz}};

endmodule : tutor_vhdl
`default_nettype wire

// File: tb/tb_tutor_vhdl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tutor_vhdl
// Description : Self-checking bench for tutor_vhdl. Two instances share the
//               stimulus; one drives a pulled-up bus and one a pulled-down
//               bus so a released (high-Z) Q is distinguishable from a
//               driven value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tutor_vhdl;

    localparam int W = 4;

    logic         CLK  = 1'b0;
    logic         CLR  = 1'b1;
    logic         CE   = 1'b0;
    logic         LOAD = 1'b0;
    logic         DIR  = 1'b0;
    logic         SEL  = 1'b0;
    logic [W-1:0] DATA = '0;
    logic         OE   = 1'b1;
    logic         LE   = 1'b0;

    wire  [W-1:0] q_pu;
    wire  [W-1:0] q_pd;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: plain integers, updated from the behavioural rules
    int m_cnt = 0;
    int m_dr  = 0;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_pull
            pullup   (q_pu[gi]);
            pulldown (q_pd[gi]);
        end
    endgenerate

    tutor_vhdl #(.WIDTH(W)) u_dut_pu (
        .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(LOAD), .DIR(DIR), .SEL(SEL),
        .DATA(DATA), .OE(OE), .LE(LE), .Q(q_pu)
    );

    tutor_vhdl #(.WIDTH(W)) u_dut_pd (
        .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(LOAD), .DIR(DIR), .SEL(SEL),
        .DATA(DATA), .OE(OE), .LE(LE), .Q(q_pd)
    );

    always #5 CLK = ~CLK;

    // Reference model
    always @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            m_cnt <= 0;
            m_dr  <= 0;
        end else begin
            if (LOAD)
                m_cnt <= int'(DATA);
            else if (CE && DIR)
                m_cnt <= (m_cnt + 1) % 16;
            else if (CE)
                m_cnt <= (m_cnt + 15) % 16;
            if (LE)
                m_dr <= int'(DATA);
        end
    end

    // Compare the bus against an expected value or against high-Z
    task automatic check(input string name, input int exp_val, input bit exp_z);
        logic [W-1:0] v_exp;
        bit           v_ok;
        v_exp = exp_val[W-1:0];
        n_tests++;
        if (exp_z)
            v_ok = (q_pu === 4'hF) && (q_pd === 4'h0);
        else
            v_ok = (q_pu === v_exp) && (q_pd === v_exp);
        if (!v_ok) begin
            n_fail++;
            if (exp_z)
                $display("FAIL %s: got pu=%b pd=%b, expected zzzz", name, q_pu, q_pd);
            else
                $display("FAIL %s: got pu=%b pd=%b, expected %b", name, q_pu, q_pd, v_exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        check("cycle", SEL ? m_dr : m_cnt, !OE);
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    typedef struct {
        logic         load;
        logic         ce;
        logic         dir;
        logic         le;
        logic         sel;
        logic         oe;
        logic [W-1:0] data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Asynchronous clear with no clock edge yet
        #1 CLR = 1'b0;
        #1 check("rst_async", 0, 1'b0);
        step();
        check("rst_held", 0, 1'b0);
        CLR = 1'b1;

        // Load then count up
        LOAD = 1'b1; DATA = 4'b0110;
        step(); check("load_6", 6, 1'b0);
        LOAD = 1'b0; CE = 1'b1; DIR = 1'b1;
        step(); check("up_7", 7, 1'b0);
        step(); check("up_8", 8, 1'b0);
        step(); check("up_9", 9, 1'b0);

        // Hold
        CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check("hold_9", 9, 1'b0);
        end

        // Wrap up from F
        LOAD = 1'b1; DATA = 4'hF;
        step(); check("load_F", 15, 1'b0);
        LOAD = 1'b0; CE = 1'b1; DIR = 1'b1;
        step(); check("wrap_up", 0, 1'b0);

        // Count down from 2 with wrap
        LOAD = 1'b1; DATA = 4'h2; CE = 1'b0;
        step(); check("load_2", 2, 1'b0);
        LOAD = 1'b0; CE = 1'b1; DIR = 1'b0;
        step(); check("down_1", 1, 1'b0);
        step(); check("down_0", 0, 1'b0);
        step(); check("wrap_down", 15, 1'b0);

        // LOAD beats counting
        LOAD = 1'b1; CE = 1'b1; DIR = 1'b1; DATA = 4'b0101;
        step(); check("load_prio", 5, 1'b0);
        LOAD = 1'b0;
        step(); check("up_6", 6, 1'b0);

        // Tri-state while the counter keeps going
        OE = 1'b0;
        #1 check("oe_off", 0, 1'b1);
        step(); step();
        check("oe_off_run", 0, 1'b1);
        OE = 1'b1;
        #1 check("oe_on_8", 8, 1'b0);

        // Data register path
        SEL = 1'b1; LE = 1'b1; DATA = 4'b0001;
        step(); check("dr_1", 1, 1'b0);
        LE = 1'b0; DATA = 4'b0101;
        step(); check("dr_hold", 1, 1'b0);
        SEL = 1'b0; CE = 1'b0;
        #1 check("sel_cnt_A", 10, 1'b0);

        // Clear between edges with counter=A, datareg=1
        CLR = 1'b0;
        #1 check("rst_mid_cnt", 0, 1'b0);
        step();
        SEL = 1'b1;
        #1 check("rst_mid_dr", 0, 1'b0);
        CLR = 1'b1; SEL = 1'b0; CE = 1'b1; DIR = 1'b1;
        step(); check("resume_1", 1, 1'b0);
        step(); check("resume_2", 2, 1'b0);

        // LE and LOAD in the same cycle
        LOAD = 1'b1; LE = 1'b1; DATA = 4'hC;
        step(); check("both_cnt", 12, 1'b0);
        LOAD = 1'b0; LE = 1'b0; CE = 1'b0; SEL = 1'b1;
        #1 check("both_dr", 12, 1'b0);

        // Mixed directed vectors, checked by the per-cycle compare
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hE};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h7};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hB};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5};
        for (int i = 0; i < 10; i++) begin
            LOAD = vecs[i].load; CE = vecs[i].ce; DIR = vecs[i].dir;
            LE = vecs[i].le; SEL = vecs[i].sel; OE = vecs[i].oe;
            DATA = vecs[i].data;
            step();
        end
        // Counter path after the table: E loaded, +1+1+1 (F,0,1), hold,
        // load 1, then -1 -1 -> F
        SEL = 1'b0; OE = 1'b1; CE = 1'b0; LOAD = 1'b0; LE = 1'b0;
        #1 check("table_cnt", 15, 1'b0);
        SEL = 1'b1;
        #1 check("table_dr", 11, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the stimulus is bounded, so this only fires on a stall
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule : tb_tutor_vhdl
`default_nettype wire
